// File: rtl/ecc_sched_pkg.sv
// Shared types and default widths for the ECC engine scheduler.
// Widths here must match the burst-error ECC engine being shared.
package ecc_sched_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_CODEWORD_WIDTH = 16;
  localparam int DEF_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } sched_state_t;

  typedef enum logic {
    OP_ENC,
    OP_DEC
  } op_t;

endpackage

// File: rtl/ecc_rr_arbiter2.sv
// Two-way round-robin arbiter between the encode and decode requesters.
// The last winner is remembered only when the scheduler actually accepts a request.
module ecc_rr_arbiter2 import ecc_sched_pkg::*; (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_encValid,
  input  logic i_decValid,
  input  logic i_accept,
  output logic o_anyValid,
  output op_t  o_grant
);

  op_t r_lastGrant;

  // Starting from DEC lets encode win the first tie after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lastGrant <= OP_DEC;
    end else if (i_accept) begin
      r_lastGrant <= o_grant;
    end
  end

  always_comb begin
    o_grant = OP_ENC;
    if (i_encValid && i_decValid) begin
      o_grant = (r_lastGrant == OP_ENC) ? OP_DEC : OP_ENC;
    end else if (i_decValid) begin
      o_grant = OP_DEC;
    end
  end

  assign o_anyValid = i_encValid | i_decValid;

endmodule

// File: rtl/ecc_engine_scheduler.sv
// Shares one ECC engine between an encode and a decode requester, one op at a time.
// Optional decode-error counter enabled by defining ECC_SCHED_ERR_CNT_EN.
module ecc_engine_scheduler import ecc_sched_pkg::*; #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CODEWORD_WIDTH = DEF_CODEWORD_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enc_req_valid,
  output logic                      enc_req_ready,
  input  logic [DATA_WIDTH-1:0]     enc_req_data,
  input  logic                      dec_req_valid,
  output logic                      dec_req_ready,
  input  logic [CODEWORD_WIDTH-1:0] dec_req_codeword,
  output logic                      enc_rsp_valid,
  input  logic                      enc_rsp_ready,
  output logic [CODEWORD_WIDTH-1:0] enc_rsp_codeword,
  output logic                      dec_rsp_valid,
  input  logic                      dec_rsp_ready,
  output logic [DATA_WIDTH-1:0]     dec_rsp_data,
  output logic                      dec_rsp_err,
`ifdef ECC_SCHED_ERR_CNT_EN
  input  logic                      err_count_clr,
  output logic [CNT_WIDTH-1:0]      err_count,
`endif
  output logic                      eng_encode_en,
  output logic                      eng_decode_en,
  output logic [DATA_WIDTH-1:0]     eng_data_in,
  output logic [CODEWORD_WIDTH-1:0] eng_codeword_in,
  input  logic [CODEWORD_WIDTH-1:0] eng_codeword_out,
  input  logic [DATA_WIDTH-1:0]     eng_data_out,
  input  logic                      eng_error_detected,
  input  logic                      eng_valid_out,
  output logic                      eng_fault
);

  sched_state_t r_state;
  sched_state_t w_nextState;
  op_t          r_op;
  op_t          w_grant;
  logic         w_anyValid;
  logic         w_accept;

  ecc_rr_arbiter2 u_arb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_encValid (enc_req_valid),
    .i_decValid (dec_req_valid),
    .i_accept   (w_accept),
    .o_anyValid (w_anyValid),
    .o_grant    (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshakes, strobes and response valids are all masked during reset so an
  // in-flight op can neither strobe the engine nor complete a response.
  always_comb begin
    w_nextState   = r_state;
    w_accept      = 1'b0;
    enc_req_ready = 1'b0;
    dec_req_ready = 1'b0;
    eng_encode_en = 1'b0;
    eng_decode_en = 1'b0;
    enc_rsp_valid = 1'b0;
    dec_rsp_valid = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_anyValid) begin
            w_accept      = 1'b1;
            enc_req_ready = (w_grant == OP_ENC);
            dec_req_ready = (w_grant == OP_DEC);
            w_nextState   = ISSUE;
          end
        end
        ISSUE: begin
          eng_encode_en = (r_op == OP_ENC);
          eng_decode_en = (r_op == OP_DEC);
          w_nextState   = CAPTURE;
        end
        CAPTURE: w_nextState = RESP;
        RESP: begin
          enc_rsp_valid = (r_op == OP_ENC);
          dec_rsp_valid = (r_op == OP_DEC);
          if ((r_op == OP_ENC && enc_rsp_ready) || (r_op == OP_DEC && dec_rsp_ready)) begin
            w_nextState = IDLE;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Operands are sampled only on the accepting cycle; results only in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op             <= OP_ENC;
      eng_data_in      <= '0;
      eng_codeword_in  <= '0;
      enc_rsp_codeword <= '0;
      dec_rsp_data     <= '0;
      dec_rsp_err      <= 1'b0;
      eng_fault        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= w_grant;
        if (w_grant == OP_ENC) begin
          eng_data_in <= enc_req_data;
        end else begin
          eng_codeword_in <= dec_req_codeword;
        end
      end
      if (r_state == CAPTURE) begin
        if (r_op == OP_ENC) begin
          enc_rsp_codeword <= eng_codeword_out;
          if (!eng_valid_out) begin
            eng_fault <= 1'b1;
          end
        end else begin
          dec_rsp_data <= eng_data_out;
          dec_rsp_err  <= eng_error_detected;
        end
      end
    end
  end

`ifdef ECC_SCHED_ERR_CNT_EN
  logic w_captureErr;

  assign w_captureErr = (r_state == CAPTURE) && (r_op == OP_DEC) && eng_error_detected;

  // Clear wins over saturation but still counts a coincident error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_count_clr) begin
      err_count <= w_captureErr ? CNT_WIDTH'(1) : '0;
    end else if (w_captureErr && (err_count != '1)) begin
      err_count <= err_count + CNT_WIDTH'(1);
    end
  end
`else
  logic [CNT_WIDTH-1:0] w_unusedCnt;
  assign w_unusedCnt = '0;
`endif

endmodule
